// File: rtl/pulse_measure.sv
// Pulse high-time / period meter fed by one-cycle edge events.
// Define PULSE_MEAS_PERIOD_EN to add period measurement (LOW state, cnt_p).
module pulse_measure #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pos_edge,
  input  logic             neg_edge,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             sat,
  output logic             overrun,
  output logic             busy
);

`ifdef PULSE_MEAS_PERIOD_EN
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;
`else
  typedef enum logic [1:0] {IDLE, HIGH} state_e;
`endif

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] inc_sat(input logic [CNT_W-1:0] v);
    return (v == MAX) ? v : v + ONE;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_h_q, cnt_h_d;
  logic [CNT_W-1:0] res_h_q, res_h_d;
  logic             sat_q, sat_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             pe, ne, done;
  logic [CNT_W-1:0] cap_h;
  logic             cap_sat;
`ifdef PULSE_MEAS_PERIOD_EN
  logic [CNT_W-1:0] cnt_p_q, cnt_p_d;
  logic [CNT_W-1:0] res_p_q, res_p_d;
  logic [CNT_W-1:0] cap_p;
`endif

  always_comb begin
    // Coincident edges carry no usable information.
    pe      = pos_edge & ~neg_edge;
    ne      = neg_edge & ~pos_edge;
    state_d = state_q;
    cnt_h_d = cnt_h_q;
    done    = 1'b0;
    cap_h   = cnt_h_q;
`ifdef PULSE_MEAS_PERIOD_EN
    cnt_p_d = cnt_p_q;
    cap_p   = cnt_p_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pe) begin
          state_d = HIGH;
          cnt_h_d = ONE;
`ifdef PULSE_MEAS_PERIOD_EN
          cnt_p_d = ONE;
`endif
        end
      end
      HIGH: begin
        if (pe) begin
          cnt_h_d = ONE;
`ifdef PULSE_MEAS_PERIOD_EN
          cnt_p_d = ONE;
`endif
        end else if (ne) begin
`ifdef PULSE_MEAS_PERIOD_EN
          state_d = LOW;
          cnt_p_d = inc_sat(cnt_p_q);
`else
          state_d = IDLE;
          done    = 1'b1;
          cnt_h_d = '0;
`endif
        end else begin
          cnt_h_d = inc_sat(cnt_h_q);
`ifdef PULSE_MEAS_PERIOD_EN
          cnt_p_d = inc_sat(cnt_p_q);
`endif
        end
      end
`ifdef PULSE_MEAS_PERIOD_EN
      LOW: begin
        if (pe) begin
          done    = 1'b1;
          state_d = HIGH;
          cnt_h_d = ONE;
          cnt_p_d = ONE;
        end else begin
          cnt_p_d = inc_sat(cnt_p_q);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    res_h_d = res_h_q;
    sat_d   = sat_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
`ifdef PULSE_MEAS_PERIOD_EN
    res_p_d = res_p_q;
    cap_sat = (cap_h == MAX) | (cap_p == MAX);
`else
    cap_sat = (cap_h == MAX);
`endif
    if (valid_q && out_ready) valid_d = 1'b0;
    // A new result may replace the old one only as it is being consumed.
    if (done) begin
      if (!valid_q || out_ready) begin
        valid_d = 1'b1;
        res_h_d = cap_h;
        sat_d   = cap_sat;
`ifdef PULSE_MEAS_PERIOD_EN
        res_p_d = cap_p;
`endif
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_h_q <= '0;
      res_h_q <= '0;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef PULSE_MEAS_PERIOD_EN
      cnt_p_q <= '0;
      res_p_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_h_q <= cnt_h_d;
      res_h_q <= res_h_d;
      sat_q   <= sat_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
`ifdef PULSE_MEAS_PERIOD_EN
      cnt_p_q <= cnt_p_d;
      res_p_q <= res_p_d;
`endif
    end
  end

  assign out_valid = valid_q;
  assign high_cnt  = res_h_q;
  assign sat       = sat_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != IDLE);
`ifdef PULSE_MEAS_PERIOD_EN
  assign period_cnt = res_p_q;
`else
  assign period_cnt = '0;
`endif

endmodule

// File: tb/tb_pulse_measure.sv
// Directed bench for pulse_measure: default width plus a CNT_W=4 copy.
// Expectations follow the build (PULSE_MEAS_PERIOD_EN defined or not).
module tb_pulse_measure;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pos_edge = 1'b0;
  logic        neg_edge = 1'b0;
  logic        out_ready = 1'b1;
  logic        v16, s16, o16, b16;
  logic [15:0] h16, p16;
  logic        v4, s4, o4, b4;
  logic [3:0]  h4, p4;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  pulse_measure #(.CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .pos_edge(pos_edge), .neg_edge(neg_edge),
    .out_valid(v16), .out_ready(out_ready), .high_cnt(h16),
    .period_cnt(p16), .sat(s16), .overrun(o16), .busy(b16)
  );

  pulse_measure #(.CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .pos_edge(pos_edge), .neg_edge(neg_edge),
    .out_valid(v4), .out_ready(out_ready), .high_cnt(h4),
    .period_cnt(p4), .sat(s4), .overrun(o4), .busy(b4)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic p, input logic n);
    pos_edge = p;
    neg_edge = n;
    @(posedge clk);
    #1;
    pos_edge = 1'b0;
    neg_edge = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) tick(1'b0, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, int'(v16), 0);
    chk({tag, "_high"}, int'(h16), 0);
    chk({tag, "_period"}, int'(p16), 0);
    chk({tag, "_sat"}, int'(s16), 0);
    chk({tag, "_ovr"}, int'(o16), 0);
    chk({tag, "_busy"}, int'(b16), 0);
  endtask

  initial begin
    reset = 1'b1;
    idle(2);
    chk_zero("rst");
    reset = 1'b0;
    out_ready = 1'b1;
`ifdef PULSE_MEAS_PERIOD_EN
    tick(1'b1, 1'b0);
    chk("p_start_busy", int'(b16), 1);
    idle(2);
    tick(1'b0, 1'b1);
    chk("p_low_busy", int'(b16), 1);
    chk("p_low_novalid", int'(v16), 0);
    idle(6);
    tick(1'b1, 1'b0);
    chk("p_base_valid", int'(v16), 1);
    chk("p_base_high", int'(h16), 3);
    chk("p_base_period", int'(p16), 10);
    chk("p_base_sat", int'(s16), 0);
    tick(1'b0, 1'b0);
    chk("p_accept_drop", int'(v16), 0);
    tick(1'b1, 1'b0);
    chk("p_restart_noresult", int'(v16), 0);
    idle(1);
    tick(1'b0, 1'b1);
    idle(2);
    tick(1'b1, 1'b0);
    chk("p_restart_high", int'(h16), 2);
    chk("p_restart_period", int'(p16), 5);
    idle(19);
    tick(1'b0, 1'b1);
    idle(4);
    tick(1'b1, 1'b0);
    chk("p_long_high", int'(h16), 20);
    chk("p_long_period", int'(p16), 25);
    chk("p_long_sat", int'(s16), 0);
    chk("p_w4_high", int'(h4), 15);
    chk("p_w4_period", int'(p4), 15);
    chk("p_w4_sat", int'(s4), 1);
    tick(1'b0, 1'b0);
    out_ready = 1'b0;
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    chk("p_ov1_valid", int'(v16), 1);
    chk("p_ov1_high", int'(h16), 2);
    chk("p_ov1_period", int'(p16), 3);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    chk("p_ov2_high", int'(h16), 2);
    chk("p_ov2_period", int'(p16), 3);
    chk("p_ov2_flag", int'(o16), 1);
    out_ready = 1'b1;
    tick(1'b0, 1'b0);
    chk("p_ov_drop", int'(v16), 0);
    chk("p_ov_sticky", int'(o16), 1);
    reset = 1'b1;
    tick(1'b0, 1'b0);
    reset = 1'b0;
    chk("p_rst_ovr", int'(o16), 0);
    chk("p_rst_busy", int'(b16), 0);
    out_ready = 1'b0;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    chk("p_sc1_high", int'(h16), 1);
    chk("p_sc1_period", int'(p16), 2);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    out_ready = 1'b1;
    tick(1'b1, 1'b0);
    chk("p_sc2_valid", int'(v16), 1);
    chk("p_sc2_high", int'(h16), 2);
    chk("p_sc2_period", int'(p16), 4);
    chk("p_sc2_ovr", int'(o16), 0);
    out_ready = 1'b0;
    tick(1'b0, 1'b0);
    reset = 1'b1;
    tick(1'b0, 1'b0);
    reset = 1'b0;
    chk_zero("p_midrst");
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    chk("p_fresh_valid", int'(v16), 1);
    chk("p_fresh_high", int'(h16), 1);
    chk("p_fresh_period", int'(p16), 2);
    chk("p_fresh_ovr", int'(o16), 0);
`else
    tick(1'b1, 1'b0);
    chk("start_busy", int'(b16), 1);
    idle(3);
    tick(1'b0, 1'b1);
    chk("base_valid", int'(v16), 1);
    chk("base_high", int'(h16), 4);
    chk("base_period", int'(p16), 0);
    chk("base_busy", int'(b16), 0);
    chk("base_sat", int'(s16), 0);
    tick(1'b0, 1'b0);
    chk("accept_drop", int'(v16), 0);
    tick(1'b0, 1'b1);
    chk("idle_neg_busy", int'(b16), 0);
    tick(1'b1, 1'b1);
    chk("both_idle_busy", int'(b16), 0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    chk("restart_noresult", int'(v16), 0);
    chk("restart_busy", int'(b16), 1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    chk("restart_high", int'(h16), 2);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    chk("both_high_busy", int'(b16), 1);
    tick(1'b0, 1'b1);
    chk("both_high_cnt", int'(h16), 2);
    tick(1'b0, 1'b0);
    out_ready = 1'b0;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    chk("ov1_high", int'(h16), 2);
    tick(1'b1, 1'b0);
    idle(4);
    tick(1'b0, 1'b1);
    chk("ov2_valid", int'(v16), 1);
    chk("ov2_high", int'(h16), 2);
    chk("ov2_flag", int'(o16), 1);
    out_ready = 1'b1;
    tick(1'b0, 1'b0);
    chk("ov_drop", int'(v16), 0);
    chk("ov_sticky", int'(o16), 1);
    tick(1'b1, 1'b0);
    idle(19);
    tick(1'b0, 1'b1);
    chk("long_high", int'(h16), 20);
    chk("long_sat", int'(s16), 0);
    chk("w4_high", int'(h4), 15);
    chk("w4_sat", int'(s4), 1);
    tick(1'b0, 1'b0);
    reset = 1'b1;
    tick(1'b0, 1'b0);
    reset = 1'b0;
    chk("rst_ovr", int'(o16), 0);
    out_ready = 1'b0;
    tick(1'b1, 1'b0);
    idle(2);
    tick(1'b0, 1'b1);
    chk("sc1_high", int'(h16), 3);
    tick(1'b1, 1'b0);
    idle(5);
    out_ready = 1'b1;
    tick(1'b0, 1'b1);
    chk("sc2_valid", int'(v16), 1);
    chk("sc2_high", int'(h16), 6);
    chk("sc2_ovr", int'(o16), 0);
    out_ready = 1'b0;
    tick(1'b1, 1'b0);
    reset = 1'b1;
    tick(1'b0, 1'b0);
    reset = 1'b0;
    chk_zero("midrst");
    tick(1'b1, 1'b0);
    idle(2);
    tick(1'b0, 1'b1);
    chk("fresh_valid", int'(v16), 1);
    chk("fresh_high", int'(h16), 3);
    chk("fresh_ovr", int'(o16), 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
